servo_bank: RTL and testbench

Multi-channel successor to the single-servo controller. Drives NUM_CH hobby-servo PWM outputs from one free-running frame counter. Each channel has its own angle target, slew speed and enable, and all channels are programmed through a single valid/ready write port. A time-multiplexed stepping engine ramps each channel's pulse width toward its target at STEP_HZ. It sits between the board control logic (switch/UART decoders) and the servo header pins.

---
 rtl/servo_bank.sv | 201 ++++++++++++++++++++
 tb/tb_servo_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank.sv
// servo_bank: NUM_CH hobby-servo PWM outputs sharing one frame counter and one valid/ready write port.
// Define SERVO_BANK_SLEW_EN to build the step prescaler and time-multiplexed slew engine.
module servo_bank #(
  parameter int NUM_CH       = 4,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 100_000,
  parameter int PERIOD_TICKS = 2000,
  parameter int MIN_PW       = 70,
  parameter int MAX_PW       = 230,
  parameter int STEP_HZ      = 20,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [7:0]        wr_angle,
  input  logic [3:0]        wr_speed,
  output logic [NUM_CH-1:0] out_sig,
  output logic [NUM_CH-1:0] busy,
  output logic              frame_start
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TICK_CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam logic signed [12:0] PW_LO = 13'(MIN_PW);
  localparam logic signed [12:0] PW_HI = 13'(MAX_PW);

  function automatic logic [11:0] sat_pw(input logic signed [12:0] v);
    if (v < PW_LO)      return 12'(MIN_PW);
    else if (v > PW_HI) return 12'(MAX_PW);
    else                return v[11:0];
  endfunction

  // Angles above 180 clamp to 180; 8/9 tick per degree maps 0..180 onto MIN_PW..MIN_PW+160.
  function automatic logic [11:0] angle_to_pw(input logic [7:0] a);
    logic [11:0] ac;
    ac = (a > 8'd180) ? 12'd180 : {4'd0, a};
    return sat_pw($signed({1'b0, (ac * 12'd8) / 12'd9 + 12'(MIN_PW)}));
  endfunction

  logic [TICK_CW-1:0] tick_cnt;
  logic               tick;
  logic [11:0]        frame_cnt;
  logic               wrap;
  logic               live;
  logic               wr_acc;

  logic [11:0]        pw      [NUM_CH];
  logic [11:0]        target  [NUM_CH];
  logic [11:0]        sh_pw   [NUM_CH];
  logic [11:0]        pw_nxt  [NUM_CH];
  logic [11:0]        tgt_nxt [NUM_CH];
  logic [NUM_CH-1:0]  sh_en;

  assign tick   = (tick_cnt == TICK_CW'(TICK_DIV - 1));
  assign wrap   = tick && (frame_cnt == 12'(PERIOD_TICKS - 1));
  assign wr_acc = wr_valid & wr_ready;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      tick_cnt    <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      live        <= 1'b0;
    end else begin
      live        <= 1'b1;
      tick_cnt    <= tick ? '0 : tick_cnt + TICK_CW'(1);
      frame_start <= wrap;
      if (wrap)      frame_cnt <= '0;
      else if (tick) frame_cnt <= frame_cnt + 12'd1;
    end
  end

`ifdef SERVO_BANK_SLEW_EN
  localparam int STEP_CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state, state_nxt;
  logic [CH_W-1:0]    sweep_idx, sweep_idx_nxt;
  logic [STEP_CW-1:0] step_cnt;
  logic               step_stb;
  logic [3:0]         speed   [NUM_CH];
  logic [3:0]         spd_nxt [NUM_CH];

  // One slew step: hold on speed 0, snap when within one step, else move speed ticks toward target.
  function automatic logic [11:0] slew_step(input logic [11:0] cur, input logic [11:0] tgt,
                                            input logic [3:0] spd);
    logic signed [12:0] diff, mag, spd_s, nxt;
    diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag   = (diff < 0) ? -diff : diff;
    spd_s = $signed({9'd0, spd});
    if (spd == 4'd0)    nxt = $signed({1'b0, cur});
    else if (mag <= spd_s) nxt = $signed({1'b0, tgt});
    else if (diff > 0)  nxt = $signed({1'b0, cur}) + spd_s;
    else                nxt = $signed({1'b0, cur}) - spd_s;
    return sat_pw(nxt);
  endfunction

  assign step_stb = (step_cnt == STEP_CW'(STEP_DIV - 1));
  assign wr_ready = live & (state == IDLE) & ~step_stb;

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      step_cnt  <= '0;
      state     <= IDLE;
      sweep_idx <= '0;
    end else begin
      step_cnt  <= step_stb ? '0 : step_cnt + STEP_CW'(1);
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      IDLE: if (step_stb) begin
        state_nxt     = SWEEP;
        sweep_idx_nxt = '0;
      end
      SWEEP: begin
        if (sweep_idx == CH_W'(NUM_CH - 1)) state_nxt = IDLE;
        else sweep_idx_nxt = sweep_idx + CH_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writes and sweep updates never coincide: wr_ready is low for the whole sweep.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pw_nxt[i]  = pw[i];
      tgt_nxt[i] = target[i];
      spd_nxt[i] = speed[i];
      if (state == SWEEP && sweep_idx == CH_W'(i))
        pw_nxt[i] = slew_step(pw[i], target[i], speed[i]);
      if (wr_acc && int'(wr_ch) == i) begin
        tgt_nxt[i] = angle_to_pw(wr_angle);
        spd_nxt[i] = wr_speed;
      end
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) speed[i] <= 4'd0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        speed[i] <= spd_nxt[i];
        busy[i]  <= (pw_nxt[i] != tgt_nxt[i]);
      end
    end
  end
`else
  logic slew_unused;

  assign slew_unused = ^wr_speed ^ (STEP_DIV > 0);
  assign wr_ready    = live;
  assign busy        = '0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pw_nxt[i]  = pw[i];
      tgt_nxt[i] = target[i];
      if (wr_acc && int'(wr_ch) == i) begin
        tgt_nxt[i] = angle_to_pw(wr_angle);
        pw_nxt[i]  = angle_to_pw(wr_angle);
      end
    end
  end
`endif

  // Shadow copies are taken on the wrap edge so every frame uses one consistent width/enable.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pw[i]     <= 12'(MIN_PW);
        target[i] <= 12'(MIN_PW);
        sh_pw[i]  <= 12'(MIN_PW);
      end
      sh_en   <= '0;
      out_sig <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pw[i]      <= pw_nxt[i];
        target[i]  <= tgt_nxt[i];
        if (wrap) sh_pw[i] <= pw[i];
        out_sig[i] <= sh_en[i] & (frame_cnt < sh_pw[i]);
      end
      if (wrap) sh_en <= en;
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Self-checking bench for servo_bank: directed and random writes against a behavioural servo model.
// Covers the slew engine when SERVO_BANK_SLEW_EN is defined and direct-write mode otherwise.
module tb_servo_bank;

  localparam int NUM_CH       = 3;
  localparam int CLK_HZ       = 2000;
  localparam int TICK_HZ      = 1000;
  localparam int PERIOD_TICKS = 300;
  localparam int MIN_PW       = 70;
  localparam int MAX_PW       = 230;
  localparam int STEP_HZ      = 40;
  localparam int CH_W         = 2;
  localparam int TDIV         = CLK_HZ / TICK_HZ;
  localparam int FRAME_CYC    = TDIV * PERIOD_TICKS;

  logic              clk;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [7:0]        wr_angle;
  logic [3:0]        wr_speed;
  logic [NUM_CH-1:0] out_sig;
  logic [NUM_CH-1:0] busy;
  logic              frame_start;

  int   total = 0;
  int   bad   = 0;
  int   m_tgt [NUM_CH];
  int   m_pw  [NUM_CH];
  int   m_spd [NUM_CH];
  int   meas  [NUM_CH];
  logic prev_ready;

  servo_bank #(
    .NUM_CH(NUM_CH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .PERIOD_TICKS(PERIOD_TICKS),
    .MIN_PW(MIN_PW), .MAX_PW(MAX_PW), .STEP_HZ(STEP_HZ)
  ) dut (
    .clk_100M(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .wr_speed(wr_speed), .out_sig(out_sig),
    .busy(busy), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_target(input int ang);
    int a;
    a = (ang > 180) ? 180 : ang;
    return (a * 8) / 9 + MIN_PW;
  endfunction

  function automatic int model_step(input int cur, input int tgt, input int spd);
    int d, r;
    d = tgt - cur;
    if (spd == 0)                         r = cur;
    else if ((d < 0 ? -d : d) <= spd)     r = tgt;
    else                                  r = (d > 0) ? cur + spd : cur - spd;
    if (r < MIN_PW) r = MIN_PW;
    if (r > MAX_PW) r = MAX_PW;
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] model_busy();
    logic [NUM_CH-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i] = (m_pw[i] != m_tgt[i]);
    return b;
  endfunction

  function automatic bit model_settled();
    return model_busy() == '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_tgt[i] = MIN_PW;
      m_pw[i]  = MIN_PW;
      m_spd[i] = 0;
    end
  endtask

  // Every bench wait goes through here; a falling wr_ready marks one slew step of all channels.
  task automatic cyc();
    @(negedge clk);
    if (!rst && prev_ready && !wr_ready)
      for (int i = 0; i < NUM_CH; i++) m_pw[i] = model_step(m_pw[i], m_tgt[i], m_spd[i]);
    prev_ready = wr_ready;
  endtask

  task automatic do_write(input int ch, input int ang, input int spd, output int waited);
    wr_ch    = ch[CH_W-1:0];
    wr_angle = ang[7:0];
    wr_speed = spd[3:0];
    wr_valid = 1'b1;
    waited   = 0;
    while (!wr_ready && waited < 100) begin
      cyc();
      waited++;
    end
    chk("write_accept_wait", (waited < 100), 1);
    if (ch < NUM_CH) begin
      m_tgt[ch] = exp_target(ang);
`ifdef SERVO_BANK_SLEW_EN
      m_spd[ch] = spd;
`else
      m_pw[ch]  = m_tgt[ch];
`endif
    end
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_step(output int low);
    int n = 0;
    low = 0;
    while (wr_ready && n < 200) begin
      cyc();
      n++;
    end
    while (!wr_ready && low < 100) begin
      low++;
      cyc();
    end
  endtask

  task automatic measure();
    int n = 0;
    int len = 0;
    while (!frame_start && n < 2 * FRAME_CYC) begin
      cyc();
      n++;
    end
    for (int i = 0; i < NUM_CH; i++) meas[i] = 0;
    do begin
      for (int i = 0; i < NUM_CH; i++) meas[i] += int'(out_sig[i]);
      cyc();
      len++;
    end while (!frame_start && len < 2 * FRAME_CYC);
    chk("frame_len", len, FRAME_CYC);
  endtask

  task automatic check_frame(input string tag);
    measure();
    for (int i = 0; i < NUM_CH; i++)
      chk($sformatf("%s_pulse_ch%0d", tag, i), meas[i], en[i] ? TDIV * m_pw[i] : 0);
  endtask

  task automatic settle(input string tag, input int max_steps);
    int low;
    int k = 0;
    while (!model_settled() && k < max_steps) begin
      wait_step(low);
      chk($sformatf("%s_busy_step%0d", tag, k), busy, model_busy());
      k++;
    end
    chk($sformatf("%s_busy_final", tag), busy, 0);
  endtask

  initial begin
    int w, low, cnt;
    rst        = 1'b1;
    en         = '0;
    wr_valid   = 1'b0;
    wr_ch      = '0;
    wr_angle   = '0;
    wr_speed   = '0;
    prev_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_sig", out_sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    cyc();
    chk("ready_after_rst", wr_ready, 1);

    en = 3'b101;
    check_frame("idle");
    repeat (10) cyc();
    en[1] = 1'b1;
    cnt = 0;
    w   = 0;
    while (!frame_start && w < 2 * FRAME_CYC) begin
      cnt += int'(out_sig[1]);
      cyc();
      w++;
    end
    chk("en_midframe_ch1", cnt, 0);
    check_frame("en_next");

`ifdef SERVO_BANK_SLEW_EN
    do_write(0, 90, 10, w);
    do_write(2, 200, 15, w);
    for (int k = 0; k < 14; k++) begin
      wait_step(low);
      chk($sformatf("sweep_low_%0d", k), low, NUM_CH + 1);
      chk($sformatf("slew_busy_%0d", k), busy, model_busy());
    end
    check_frame("slew");

    w = 0;
    while (wr_ready && w < 200) begin
      cyc();
      w++;
    end
    do_write(1, 45, 5, w);
    chk("held_valid_wait", w, NUM_CH);
    settle("held", 40);

    for (int r = 0; r < 6; r++)
      do_write($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(1, 15), w);
    settle("rand", 200);
    check_frame("rand");

    do_write(1, 180, 0, w);
    wait_step(low);
    wait_step(low);
    chk("hold_busy", busy, model_busy());
`else
    do_write(1, 90, 0, w);
    chk("direct_busy_a", busy, 0);
    check_frame("direct90");
    do_write(1, 0, 7, w);
    chk("direct_busy_b", busy, 0);
    check_frame("direct0");
    do_write(0, 90, 10, w);
    do_write(2, 200, 15, w);
    check_frame("direct_clamp");
    do_write(3, 120, 3, w);
    check_frame("dropped_ch");
    for (int r = 0; r < 6; r++)
      do_write($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 15), w);
    check_frame("rand");
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      cnt += int'(!wr_ready);
      cyc();
    end
    chk("ready_always_high", cnt, 0);
`endif

    en = 3'b111;
    w  = 0;
    while (!frame_start && w < 2 * FRAME_CYC) begin
      cyc();
      w++;
    end
    repeat (20) cyc();
    chk("pulse_before_rst", out_sig, 3'b111);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_sig", out_sig, 0);
    chk("async_rst_ready", wr_ready, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cnt = 0;
    w   = 0;
    while (!frame_start && w < 2 * FRAME_CYC) begin
      cnt += int'(out_sig != '0);
      cyc();
      w++;
    end
    chk("post_rst_disabled", cnt, 0);
    check_frame("post_rst");
    chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
